// File: rtl/apb_mailbox_fifo.sv
// APB completer exposing a 32-bit mailbox: a CPU-to-hardware TX FIFO and a
// hardware-to-CPU RX FIFO, with status/control registers and a level interrupt.
`timescale 1ns/1ps

module apb_mailbox_fifo #(
    parameter int DEPTH       = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic [9:0]  PADDR,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        MBXINT
);

    localparam int              AW           = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT     = (AW+1)'(DEPTH);
    localparam logic [2:0]      WS           = 3'(WAIT_STATES);
    localparam logic [9:0]      ADDR_DATA    = 10'd0;
    localparam logic [9:0]      ADDR_STATUS  = 10'd1;
    localparam logic [9:0]      ADDR_CTRL    = 10'd2;
    localparam logic [9:0]      ADDR_INTSTAT = 10'd3;

    logic [2:0]    wcnt;
    logic          access;
    logic          done;
    logic          sel_data;
    logic          sel_status;
    logic          sel_ctrl;
    logic          sel_int;
    logic          mapped;
    logic          wr_data;
    logic          rd_data;
    logic          wr_ctrl;
    logic          wr_int;
    logic          tx_flush;
    logic          rx_flush;

    logic [31:0]   tx_mem [DEPTH];
    logic [AW-1:0] tx_wptr;
    logic [AW-1:0] tx_rptr;
    logic [AW:0]   tx_cnt;
    logic          tx_empty;
    logic          tx_full;
    logic          tx_push;
    logic          tx_pop;

    logic [31:0]   rx_mem [DEPTH];
    logic [AW-1:0] rx_wptr;
    logic [AW-1:0] rx_rptr;
    logic [AW:0]   rx_cnt;
    logic          rx_empty;
    logic          rx_full;
    logic          rx_push;
    logic          rx_pop;

    logic [2:0]    ctrl;
    logic          txovr;
    logic          rxund;
    logic          unused_pwdata;

    assign access = PSEL & PENABLE;
    assign PREADY = ~access | (wcnt == WS);
    assign done   = access & PREADY;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wcnt <= '0;
        end else if (!PSEL || done) begin
            wcnt <= '0;
        end else if (access) begin
            wcnt <= wcnt + 3'd1;
        end
    end

    assign sel_data   = (PADDR == ADDR_DATA);
    assign sel_status = (PADDR == ADDR_STATUS);
    assign sel_ctrl   = (PADDR == ADDR_CTRL);
    assign sel_int    = (PADDR == ADDR_INTSTAT);
    assign mapped     = sel_data | sel_status | sel_ctrl | sel_int;

    // Every register side effect is qualified by the completion cycle.
    assign wr_data  = done &  PWRITE & sel_data;
    assign rd_data  = done & ~PWRITE & sel_data;
    assign wr_ctrl  = done &  PWRITE & sel_ctrl;
    assign wr_int   = done &  PWRITE & sel_int;
    assign tx_flush = wr_ctrl & PWDATA[4];
    assign rx_flush = wr_ctrl & PWDATA[5];

    assign unused_pwdata = ^{PWDATA[31:6], PWDATA[3]};

    assign tx_empty = (tx_cnt == '0);
    assign tx_full  = (tx_cnt == FULL_CNT);
    assign tx_push  = wr_data & ~tx_full;
    assign tx_pop   = tx_valid & tx_ready;
    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_valid ? tx_mem[tx_rptr] : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            tx_cnt  <= '0;
        end else if (tx_flush) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            tx_cnt  <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
            else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (tx_push) tx_mem[tx_wptr] <= PWDATA;
    end

    assign rx_empty = (rx_cnt == '0);
    assign rx_full  = (rx_cnt == FULL_CNT);
    assign rx_ready = ~rx_full;
    assign rx_push  = rx_valid & rx_ready;
    assign rx_pop   = rd_data & ~rx_empty;

    // A flush on the same edge discards the producer handshake and any pop.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
            rx_cnt  <= '0;
        end else if (rx_flush) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
            rx_cnt  <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
            if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
            else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (rx_push && !rx_flush) rx_mem[rx_wptr] <= rx_data;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl   <= '0;
            txovr  <= 1'b0;
            rxund  <= 1'b0;
            MBXINT <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl <= PWDATA[2:0];
            txovr  <= (wr_data & tx_full)  | (txovr & ~(wr_int & PWDATA[0]));
            rxund  <= (rd_data & rx_empty) | (rxund & ~(wr_int & PWDATA[1]));
            MBXINT <= (ctrl[0] & tx_empty) | (ctrl[1] & ~rx_empty) |
                      (ctrl[2] & (txovr | rxund));
        end
    end

    assign PSLVERR = done & (~mapped |
                             (sel_data & PWRITE & tx_full) |
                             (sel_data & ~PWRITE & rx_empty) |
                             (sel_status & PWRITE));

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (PADDR)
                ADDR_DATA:    if (!rx_empty) PRDATA = rx_mem[rx_rptr];
                ADDR_STATUS:  PRDATA = {20'd0, 4'(rx_cnt), 4'(tx_cnt),
                                        rx_full, rx_empty, tx_full, tx_empty};
                ADDR_CTRL:    PRDATA = {29'd0, ctrl};
                ADDR_INTSTAT: PRDATA = {30'd0, rxund, txovr};
                default:      PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_mailbox_fifo.sv
// Scoreboard bench for apb_mailbox_fifo: a queue-based mailbox model predicts
// each APB response and TX handshake; a monitor compares when the DUT presents them.
`timescale 1ns/1ps

module tb_apb_mailbox_fifo;

    localparam int DEPTH       = 8;
    localparam int WAIT_STATES = 1;

    logic        PCLK;
    logic        PRESETn;
    logic        PSEL;
    logic [9:0]  PADDR;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        MBXINT;

    apb_mailbox_fifo #(.DEPTH(DEPTH), .WAIT_STATES(WAIT_STATES)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PADDR(PADDR),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .MBXINT(MBXINT)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        apb_exp[$];
    logic [31:0] tx_model[$];
    logic [31:0] rx_model[$];
    logic [2:0]  m_ctrl;
    logic        m_txovr;
    logic        m_rxund;
    int          vectors = 0;
    int          miscompares = 0;
    int          wait_cnt = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_status();
        int ts = tx_model.size();
        int rs = rx_model.size();
        logic [31:0] s = '0;
        s[0]    = (ts == 0);
        s[1]    = (ts == DEPTH);
        s[2]    = (rs == 0);
        s[3]    = (rs == DEPTH);
        s[7:4]  = 4'(ts % 16);
        s[11:8] = 4'(rs % 16);
        return s;
    endfunction

    function automatic logic model_irq();
        return (m_ctrl[0] && tx_model.size() == 0) ||
               (m_ctrl[1] && rx_model.size() != 0) ||
               (m_ctrl[2] && (m_txovr || m_rxund));
    endfunction

    // Monitor: compares completed APB transfers and TX handshakes against the scoreboard.
    always @(negedge PCLK) begin
        if (!PRESETn || !PSEL) begin
            wait_cnt = 0;
        end else if (PENABLE) begin
            if (!PREADY) begin
                wait_cnt++;
                check_output("pslverr_in_wait", {31'd0, PSLVERR}, 32'd0);
            end else begin
                exp_t e;
                check_output("wait_states", wait_cnt, WAIT_STATES);
                if (apb_exp.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_completion: got completion, expected none at %0t", $time);
                end else begin
                    e = apb_exp.pop_front();
                    check_output("prdata", PRDATA, e.rdata);
                    check_output("pslverr", {31'd0, PSLVERR}, {31'd0, e.err});
                end
                wait_cnt = 0;
            end
        end
        if (PRESETn && tx_valid && tx_ready) begin
            if (tx_model.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_tx_pop: got %h, expected no data at %0t", tx_data, $time);
            end else begin
                check_output("tx_data", tx_data, tx_model.pop_front());
            end
        end
    end

    // One APB transfer; optional consumer pop / producer push land on its completion edge.
    task automatic apply_stimulus(input logic wr, input logic [9:0] addr, input logic [31:0] wdata,
                                  input logic pop_en = 1'b0, input logic push_en = 1'b0,
                                  input logic [31:0] push_data = 32'd0);
        exp_t e;
        int   rx_before;
        logic rx_flushed;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        for (int w = 0; w < WAIT_STATES; w++) begin
            @(posedge PCLK); #1;
        end
        tx_ready = pop_en; rx_valid = push_en; rx_data = push_data;
        e.rdata = '0; e.err = 1'b0;
        rx_before = rx_model.size();
        rx_flushed = 1'b0;
        case (addr)
            10'd0: begin
                if (wr) begin
                    if (tx_model.size() == DEPTH) begin e.err = 1'b1; m_txovr = 1'b1; end
                    else tx_model.push_back(wdata);
                end else begin
                    if (rx_before == 0) begin e.err = 1'b1; m_rxund = 1'b1; end
                    else e.rdata = rx_model.pop_front();
                end
            end
            10'd1: begin
                if (wr) e.err = 1'b1;
                else    e.rdata = model_status();
            end
            10'd2: begin
                if (wr) begin
                    m_ctrl = wdata[2:0];
                    if (wdata[4]) tx_model.delete();
                    if (wdata[5]) begin rx_model.delete(); rx_flushed = 1'b1; end
                end else begin
                    e.rdata = {29'd0, m_ctrl};
                end
            end
            10'd3: begin
                if (wr) begin
                    if (wdata[0]) m_txovr = 1'b0;
                    if (wdata[1]) m_rxund = 1'b0;
                end else begin
                    e.rdata = {30'd0, m_rxund, m_txovr};
                end
            end
            default: e.err = 1'b1;
        endcase
        if (push_en && !rx_flushed && rx_before < DEPTH) rx_model.push_back(push_data);
        apb_exp.push_back(e);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic produce(input logic [31:0] d);
        @(posedge PCLK); #1;
        rx_valid = 1'b1; rx_data = d;
        #3;
        check_output("rx_ready", {31'd0, rx_ready}, {31'd0, rx_model.size() < DEPTH});
        if (rx_model.size() < DEPTH) rx_model.push_back(d);
        @(posedge PCLK); #1;
        rx_valid = 1'b0;
    endtask

    task automatic drain();
        int budget = DEPTH + 4;
        tx_ready = 1'b1;
        while (tx_model.size() != 0 && budget > 0) begin
            @(posedge PCLK); #1;
            budget--;
        end
        tx_ready = 1'b0;
        if (budget == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain_timeout: got %0d entries left, expected 0", tx_model.size());
        end
        check_output("tx_valid_after_drain", {31'd0, tx_valid}, {31'd0, tx_model.size() != 0});
    endtask

    task automatic idle();
        @(posedge PCLK); #1;
    endtask

    task automatic clear_model();
        tx_model.delete(); rx_model.delete(); apb_exp.delete();
        m_ctrl = '0; m_txovr = 1'b0; m_rxund = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_pready"},  {31'd0, PREADY},   32'd1);
        check_output({tag, "_pslverr"}, {31'd0, PSLVERR},  32'd0);
        check_output({tag, "_prdata"},  PRDATA,            32'd0);
        check_output({tag, "_tx_valid"},{31'd0, tx_valid}, 32'd0);
        check_output({tag, "_rx_ready"},{31'd0, rx_ready}, 32'd1);
        check_output({tag, "_mbxint"},  {31'd0, MBXINT},   32'd0);
    endtask

    task automatic do_reset();
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        clear_model();
        repeat (2) @(posedge PCLK);
        #1;
        check_reset_outputs("reset");
        PRESETn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        do_reset();

        // Reset STATUS read with one wait state.
        apply_stimulus(1'b1 ^ 1'b1, 10'd1, 32'd0);

        // Fill TX, overflow, then drain in order.
        for (int i = 1; i <= 8; i++) apply_stimulus(1'b1, 10'd0, 32'hA5A5_0000 + i);
        apply_stimulus(1'b0, 10'd1, 32'd0);
        apply_stimulus(1'b1, 10'd0, 32'hDEAD_BEEF);
        apply_stimulus(1'b0, 10'd3, 32'd0);
        drain();
        apply_stimulus(1'b1, 10'd3, 32'd1);

        // Producer fills RX; CPU reads past empty.
        produce(32'h11);
        produce(32'h22);
        repeat (3) apply_stimulus(1'b0, 10'd0, 32'd0);
        apply_stimulus(1'b0, 10'd3, 32'd0);
        apply_stimulus(1'b1, 10'd3, 32'd3);

        // Simultaneous push and pop at 7 entries across pointer wrap.
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 10'd0, 32'hB000_0000 + i);
        drain();
        for (int i = 0; i < 7; i++) apply_stimulus(1'b1, 10'd0, 32'hC000_0000 + i);
        apply_stimulus(1'b1, 10'd0, 32'hC000_0007, 1'b1);
        apply_stimulus(1'b0, 10'd1, 32'd0);
        drain();

        // RX-not-empty interrupt and its removal by rx_flush.
        apply_stimulus(1'b1, 10'd2, 32'h02);
        produce(32'h33);
        check_output("mbxint_handshake_cycle", {31'd0, MBXINT}, 32'd0);
        idle();
        check_output("mbxint_rise", {31'd0, MBXINT}, 32'd1);
        apply_stimulus(1'b1, 10'd2, 32'h20);
        check_output("mbxint_flush_cycle", {31'd0, MBXINT}, 32'd1);
        idle();
        check_output("mbxint_fall", {31'd0, MBXINT}, 32'd0);
        apply_stimulus(1'b0, 10'd1, 32'd0);

        // Unmapped read.
        apply_stimulus(1'b0, 10'h3FC, 32'd0);

        // Reset asserted during a wait state of a DATA write.
        produce(32'h44);
        apply_stimulus(1'b1, 10'd0, 32'h55);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 10'd0; PWDATA = 32'hCAFE_F00D;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #2;
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        clear_model();
        #1;
        check_reset_outputs("midreset");
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        apply_stimulus(1'b0, 10'd1, 32'd0);

        // Randomized traffic against the queue model.
        for (int n = 0; n < 400; n++) begin
            int          op   = $urandom_range(0, 9);
            logic        pop  = ($urandom_range(0, 3) == 0);
            logic        push = ($urandom_range(0, 3) == 0);
            logic [31:0] d    = $urandom;
            logic [31:0] pd   = $urandom;
            case (op)
                0, 1, 2: apply_stimulus(1'b1, 10'd0, d, pop, push, pd);
                3, 4:    apply_stimulus(1'b0, 10'd0, 32'd0, pop, push, pd);
                5:       apply_stimulus(1'b0, 10'd1, 32'd0, pop, push, pd);
                6:       apply_stimulus(1'b1, 10'd2, d & 32'h3F, 1'b0, push, pd);
                7: begin
                    case ($urandom_range(0, 2))
                        0:       apply_stimulus(1'b0, 10'd2, 32'd0, pop, push, pd);
                        1:       apply_stimulus(1'b0, 10'd3, 32'd0, pop, push, pd);
                        default: apply_stimulus(1'b1, 10'd3, d & 32'h3, pop, push, pd);
                    endcase
                end
                8:       apply_stimulus(1'($urandom_range(0, 1)), 10'($urandom_range(4, 1023)), d, pop, push, pd);
                default: begin
                    if ($urandom_range(0, 1) == 0) begin
                        repeat (3) produce($urandom);
                    end else begin
                        drain();
                    end
                end
            endcase
            idle();
            check_output("mbxint_random", {31'd0, MBXINT}, {31'd0, model_irq()});
        end

        drain();
        apply_stimulus(1'b0, 10'd1, 32'd0);
        repeat (2) idle();
        check_output("pending_expectations", apb_exp.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb_mailbox_fifo.md
Name: apb_mailbox_fifo

Overview:
- APB completer (responder) that gives the APB bridge master a 32-bit mailbox to local hardware.
- TX FIFO: CPU writes through APB; a hardware consumer drains it through a valid/ready port.
- RX FIFO: a hardware producer fills it through a valid/ready port; the CPU reads it through APB.
- Sits on an o_psel line of the bridge, alongside the timer and UART completers. Drives an interrupt into the core's Interrupt OR-tree.

Parameters:
- DEPTH, 8: entries per FIFO. Power of two, at least 2.
- WAIT_STATES, 1: PREADY-low cycles inserted in every access phase. Range 0..7.

Ports:
- PCLK  in  1  clock; all logic is on the rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  APB select.
- PADDR  in  10  word address [11:2].
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error.
- tx_data  out  32  head of the TX FIFO.
- tx_valid  out  1  TX FIFO not empty.
- tx_ready  in  1  consumer pops TX when tx_valid & tx_ready.
- rx_data  in  32  producer data.
- rx_valid  in  1  producer has data.
- rx_ready  out  1  equals ~rx_full; producer pushes when rx_valid & rx_ready.
- MBXINT  out  1  registered interrupt.

Behaviour:
- Register map (PADDR word index):
  - 0x000 DATA: write pushes TX; read pops RX.
  - 0x001 STATUS (RO): [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [7:4] tx_count, [11:8] rx_count.
  - 0x002 CTRL (RW [2:0]): [0] txempty_ie, [1] rxne_ie, [2] err_ie. Bits [4] tx_flush and [5] rx_flush are write-only and self-clearing; they read 0.
  - 0x003 INTSTAT: [0] txovr, [1] rxund. Write 1 to clear.
  - Any other address is unmapped.
- Reset values: PRDATA=0, PREADY=1, PSLVERR=0, tx_valid=0, rx_ready=1, MBXINT=0, CTRL=0, INTSTAT=0. Both FIFOs empty, wait counter 0.
- Reset may assert mid-transfer or mid-FIFO. It clears everything immediately, with no partial push or pop.
- Wait states:
  - The counter wcnt increments while PSEL & PENABLE & ~PREADY.
  - PREADY = ~(PSEL & PENABLE) | (wcnt == WAIT_STATES).
  - wcnt clears when the transfer completes or PSEL drops.
  - WAIT_STATES=0 gives zero-wait transfers.
- Completion cycle is C = PSEL & PENABLE & PREADY. All register side effects (push, pop, CTRL/INTSTAT updates, flags) occur only on the rising edge that ends C.
- Setup-phase and wait-state cycles have no side effects.
- PRDATA:
  - Combinational decode while PSEL & ~PWRITE; 0 otherwise.
  - DATA read returns the RX head, or 0 if RX is empty.
  - Unmapped reads return 0.
- PSLVERR is driven only during C, and is 0 at all other times. It is 1 when any of these holds:
  - unmapped address, read or write;
  - write to DATA with tx_full (no push; txovr is set);
  - read of DATA with rx_empty (no pop; rxund is set);
  - write to STATUS (ignored).
- FIFOs: circular buffers with log2(DEPTH)-bit pointers that wrap naturally, and a count of width log2(DEPTH)+1.
- Count fields in STATUS are zero-extended or truncated to 4 bits. A full FIFO at DEPTH=16 therefore reads 0 in the field but has the full bit set.
- Simultaneous TX events (APB push and consumer pop on the same edge):
  - Push acceptance is judged on pre-edge full.
  - At full, the push is rejected with an error even though a pop occurs.
  - Otherwise both happen and the count is unchanged.
- Simultaneous RX events: producer push and APB pop on the same edge are both performed. A producer push is impossible when full because rx_ready=0.
- Flush:
  - A CTRL write with tx_flush/rx_flush empties that FIFO on the completion edge.
  - Flush has priority over a same-edge push or pop on that FIFO; the concurrent hardware handshake is discarded.
- INTSTAT: a set event has priority over a same-edge write-1-to-clear.
- Interrupt: MBXINT is registered, one cycle after its condition:
  - MBXINT <= (txempty_ie & tx_empty) | (rxne_ie & ~rx_empty) | (err_ie & (txovr | rxund)).

Test Plan:
- Reset, then read STATUS with WAIT_STATES=1. Required: PREADY low for exactly 1 access cycle, PRDATA=0x00000005, PSLVERR=0.
- Write DATA 0xA5A5_0001..0xA5A5_0008 (8 pushes) with tx_ready=0. Required: tx_full=1 and tx_count field = 8.
  - 9th write of 0xDEAD_BEEF: PSLVERR=1, INTSTAT=0x1.
  - Then raise tx_ready: tx_data sequence 0xA5A5_0001..8 in order, followed by tx_valid=0.
- Producer pushes 0x11, 0x22, then APB reads DATA three times. Required: 0x11 then 0x22 with PSLVERR=0; the third read gives PRDATA=0, PSLVERR=1, and sets rxund.
- TX holds 7 entries, APB write and tx_ready pop complete on the same edge. Required: tx_count stays 7, and the FIFO order is preserved across pointer wrap.
- Write CTRL=0x02, then producer pushes 0x33. Required: MBXINT rises the cycle after rx_ready handshake.
  - CTRL write 0x20 (rx_flush): rx_empty=1 and MBXINT falls one cycle later.
- Read PADDR=0x3FC. Required: PSLVERR=1, PRDATA=0.
  - Assert PRESETn low during a wait state: PREADY=1, all FIFOs empty, no push recorded.
